// File: rtl/dmem_master_if.sv
// Data-memory bus between dmem_master and a word-addressed RAM.
interface dmem_master_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;

  modport master (output mem_we, output mem_addr, output mem_datain, input mem_dataout);
  modport slave  (input mem_we, input mem_addr, input mem_datain, output mem_dataout);
endinterface

// File: rtl/dmem_master.sv
// Data-memory test master: fill / fill-increment / check-increment / checksum over a 32-word window.
// Optional: define DMEM_MASTER_CHECKSUM_EN to enable op 11 (checksum); otherwise op 11 completes with error.
module dmem_master (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start_i,
  input  logic [1:0]    op_i,
  input  logic [4:0]    base_word_i,
  input  logic [5:0]    count_i,
  input  logic [31:0]   seed_i,
  dmem_master_if.master mem,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic [4:0]    err_addr_o,
  output logic [31:0]   result_o
);
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 5;
  localparam int unsigned CW = 6;

  localparam logic [1:0] OP_FILL_C = 2'b00;
  localparam logic [1:0] OP_CHECK  = 2'b10;
  localparam logic [1:0] OP_SUM    = 2'b11;

`ifdef DMEM_MASTER_CHECKSUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d, i_q, i_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] seed_q, seed_d, pat_q, pat_d;
  logic          we_q, we_d;
  logic [DW-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [IW-1:0] erra_q, erra_d;
  logic [DW-1:0] res_q, res_d;
  logic          last_c;

  // Byte address of a word; bit 7 stays clear so the IO region is never touched.
  function automatic logic [DW-1:0] word_addr(input logic [IW-1:0] idx);
    return {24'b0, 1'b0, idx, 2'b00};
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    idx_d   = idx_q;
    seed_d  = seed_q;
    pat_d   = pat_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    erra_d  = erra_q;
    res_d   = res_q;
    last_c  = ((i_q + CW'(1)) == cnt_q);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d   = op_i;
          cnt_d  = count_i;
          seed_d = seed_i;
          idx_d  = base_word_i;
          pat_d  = seed_i;
          i_d    = '0;
          err_d  = 1'b0;
          erra_d = '0;
          res_d  = '0;
          if ((op_i == OP_SUM) && !SUM_EN) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (count_i == '0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            busy_d = 1'b1;
            addr_d = word_addr(base_word_i);
            if (!op_i[1]) begin
              we_d    = 1'b1;
              wdata_d = seed_i;
              state_d = WRITE;
            end else begin
              state_d = RD_ADDR;
            end
          end
        end
      end

      WRITE: begin
        if (last_c) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          i_d     = i_q + CW'(1);
          idx_d   = idx_q + IW'(1);
          pat_d   = pat_q + DW'(1);
          we_d    = 1'b1;
          addr_d  = word_addr(idx_q + IW'(1));
          wdata_d = (op_q == OP_FILL_C) ? seed_q : (pat_q + DW'(1));
        end
      end

      RD_ADDR: state_d = RD_WAIT;

      RD_WAIT: begin
        // Read data for the word addressed in RD_ADDR is consumed here.
        if (op_q == OP_CHECK) begin
          if (mem.mem_dataout != pat_q) begin
            res_d = res_q + DW'(1);
            if (!err_q) begin
              err_d  = 1'b1;
              erra_d = idx_q;
            end
          end
        end else begin
`ifdef DMEM_MASTER_CHECKSUM_EN
          res_d = res_q + mem.mem_dataout;
`endif
        end
        if (last_c) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          i_d     = i_q + CW'(1);
          idx_d   = idx_q + IW'(1);
          pat_d   = pat_q + DW'(1);
          addr_d  = word_addr(idx_q + IW'(1));
          state_d = RD_ADDR;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      i_q     <= '0;
      idx_q   <= '0;
      seed_q  <= '0;
      pat_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      erra_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      idx_q   <= idx_d;
      seed_q  <= seed_d;
      pat_q   <= pat_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      erra_q  <= erra_d;
      res_q   <= res_d;
    end
  end

  assign mem.mem_we     = we_q;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_datain = wdata_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = err_q;
  assign err_addr_o     = erra_q;
  assign result_o       = res_q;
endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master: random commands against a word-array reference model, scoreboarded bus writes and completions.
`timescale 1ns/1ps
module tb_dmem_master;
`ifdef DMEM_MASTER_CHECKSUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  base_word;
  logic [5:0]  count;
  logic [31:0] seed;
  logic        busy, done, error;
  logic [4:0]  err_addr;
  logic [31:0] result;

  dmem_master_if bus ();

  dmem_master dut (
    .clock(clock), .resetn(resetn), .start_i(start), .op_i(op), .base_word_i(base_word),
    .count_i(count), .seed_i(seed), .mem(bus.master), .busy_o(busy), .done_o(done),
    .error_o(error), .err_addr_o(err_addr), .result_o(result)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM on the bus, plus a bench-side write port for corrupting words.
  logic [31:0] ram [32];
  logic        poke_en;
  logic [4:0]  poke_idx;
  logic [31:0] poke_data;
  always @(posedge clock) begin
    if (bus.mem_we) ram[bus.mem_addr[6:2]] <= bus.mem_datain;
    if (poke_en) ram[poke_idx] <= poke_data;
    bus.mem_dataout <= ram[bus.mem_addr[6:2]];
  end

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic err; logic [4:0] ea; logic [31:0] res; } rsp_t;

  wr_t         exp_wr[$];
  rsp_t        exp_rsp[$];
  logic [31:0] ref_mem [32];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [31:0] waddr(input logic [4:0] idx);
    return {24'b0, 1'b0, idx, 2'b00};
  endfunction

  // Monitor: every bus write and every completion pulse is matched against the scoreboard.
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      if (bus.mem_we) begin
        if (exp_wr.size() == 0) fail_now("unexpected_write", 1, 0);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
          check("wr_data", 64'(bus.mem_datain), 64'(e.data));
        end
      end
      if (done) begin
        if (exp_rsp.size() == 0) fail_now("unexpected_done", 1, 0);
        else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          check("error", 64'(error), 64'(r.err));
          check("err_addr", 64'(err_addr), 64'(r.ea));
          check("result", 64'(result), 64'(r.res));
          check("writes_missing", 64'(exp_wr.size()), 64'(0));
        end
      end
      if (busy) check("addr_bit7", 64'(bus.mem_addr[7]), 64'(0));
    end
  end

  task automatic check_reset_state();
    check("rst_we", 64'(bus.mem_we), 64'(0));
    check("rst_addr", 64'(bus.mem_addr), 64'(0));
    check("rst_datain", 64'(bus.mem_datain), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_err_addr", 64'(err_addr), 64'(0));
    check("rst_result", 64'(result), 64'(0));
  endtask

  task automatic poke(input logic [4:0] i, input logic [31:0] d);
    poke_en = 1'b1; poke_idx = i; poke_data = d; ref_mem[i] = d;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // Issue one command, predict its writes/response from the model, and wait for completion.
  task automatic issue(input logic [1:0] o, input logic [4:0] b, input logic [5:0] c,
                       input logic [31:0] s, input bit noise);
    rsp_t r; wr_t w; logic [4:0] idx; int exp_busy; int cycles; int busy_cycles;
    r = '0;
    exp_busy = 0;
    if (o == 2'b11 && !SUM_EN) r.err = 1'b1;
    else begin
      for (int i = 0; i < int'(c); i++) begin
        idx = b + 5'(i);
        case (o)
          2'b00, 2'b01: begin
            w.addr = waddr(idx);
            w.data = (o == 2'b00) ? s : s + 32'(i);
            exp_wr.push_back(w);
            ref_mem[idx] = w.data;
          end
          2'b10: if (ref_mem[idx] != s + 32'(i)) begin
            if (!r.err) r.ea = idx;
            r.err = 1'b1;
            r.res = r.res + 32'd1;
          end
          default: r.res = r.res + ref_mem[idx];
        endcase
      end
      exp_busy = (o[1] ? 2 : 1) * int'(c);
    end
    exp_rsp.push_back(r);

    start = 1'b1; op = o; base_word = b; count = c; seed = s;
    @(negedge clock);
    start = 1'b0; op = 2'($urandom); base_word = 5'($urandom); count = 6'($urandom); seed = $urandom;
    cycles = 0;
    busy_cycles = 0;
    while (!done && cycles < 200) begin
      if (busy) busy_cycles++;
      if (noise && busy && cycles == 1) begin
        start = 1'b1; op = 2'($urandom); base_word = 5'($urandom); count = 6'($urandom_range(1, 32));
      end else start = 1'b0;
      @(negedge clock);
      cycles++;
    end
    start = 1'b0;
    if (!done) fail_now("done_timeout", cycles, 200);
    check("busy_cycles", 64'(busy_cycles), 64'(exp_busy));
    @(negedge clock);
    check("done_one_cycle", 64'(done), 64'(0));
    check("error_held", 64'(error), 64'(r.err));
  endtask

  initial begin
    logic [31:0] fs; logic [4:0] fb; logic [5:0] fc;
    logic [1:0] o; logic [4:0] b; logic [5:0] c; logic [31:0] s;
    start = 1'b0; op = '0; base_word = '0; count = '0; seed = '0;
    poke_en = 1'b0; poke_idx = '0; poke_data = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_state();
    resetn = 1'b1;
    @(negedge clock);

    issue(2'b01, 5'd0, 6'd32, $urandom, 1'b0);
    issue(2'b01, 5'd4, 6'd3, 32'h10, 1'b0);
    issue(2'b00, 5'd30, 6'd4, 32'hA5, 1'b0);
    issue(2'b01, 5'd4, 6'd3, 32'h10, 1'b0);
    poke(5'd5, 32'd0);
    issue(2'b10, 5'd4, 6'd3, 32'h10, 1'b0);
    check("corrupt_result", 64'(result), 64'(1));
    check("corrupt_err_addr", 64'(err_addr), 64'(5));

    issue(2'b01, 5'd0, 6'd4, 32'd1, 1'b0);
    issue(2'b11, 5'd0, 6'd4, 32'd0, 1'b0);
    if (SUM_EN) check("checksum", 64'(result), 64'(10));
    else check("sum_disabled_addr", 64'(bus.mem_addr), 64'(32'h0C));

    issue(2'b00, 5'd7, 6'd0, 32'h55, 1'b1);
    issue(2'b01, 5'd12, 6'd6, 32'h200, 1'b1);

    // Abort a fill after two writes have been observed.
    w_abort: begin
      wr_t w;
      for (int i = 0; i < 2; i++) begin
        w.addr = waddr(5'd10 + 5'(i)); w.data = 32'h100 + 32'(i);
        exp_wr.push_back(w);
      end
      start = 1'b1; op = 2'b01; base_word = 5'd10; count = 6'd8; seed = 32'h100;
      @(negedge clock);
      start = 1'b0;
      @(posedge clock); @(posedge clock);
      #2 resetn = 1'b0;
      #1;
      check_reset_state();
      check("abort_writes_seen", 64'(exp_wr.size()), 64'(0));
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      ref_mem[10] = 32'h100; ref_mem[11] = 32'h101;
      repeat (20) @(negedge clock);
      check("no_resume_busy", 64'(busy), 64'(0));
    end
    issue(2'b01, 5'd10, 6'd8, 32'h300, 1'b0);
    issue(2'b10, 5'd10, 6'd8, 32'h300, 1'b0);

    fs = 32'h300; fb = 5'd10; fc = 6'd8;
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom); b = 5'($urandom); c = 6'($urandom_range(0, 32)); s = $urandom;
      if (o == 2'b01) begin fs = s; fb = b; fc = c; end
      if (o == 2'b10 && $urandom_range(0, 1) == 1) begin
        s = fs; b = fb; c = fc;
        if ($urandom_range(0, 1) == 1) poke(b + 5'($urandom_range(0, 31)), $urandom);
      end
      issue(o, b, c, s, 1'($urandom));
    end

    check("rsp_queue_empty", 64'(exp_rsp.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_master.md
DMEM_MASTER -- requirements
Module: dmem_master

Interface
REQ-001 The interface SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clock  in  1  system clock; all state changes on the rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  command strobe; sampled only in IDLE.
REQ-005 op  in  2  operation: 00 fill-constant, 01 fill-increment, 10 check-increment, 11 checksum.
REQ-006 base_word  in  5  first RAM word index.
REQ-007 count  in  6  number of words, 0..32.
REQ-008 seed  in  32  fill constant or first pattern value.
REQ-009 mem_we  out  1  write enable to the data-memory bus, registered.
REQ-010 mem_addr  out  32  byte address to the data-memory bus, registered.
REQ-011 mem_datain  out  32  write data to the data-memory bus, registered.
REQ-012 mem_dataout  in  32  read data from the data-memory bus.
REQ-013 busy  out  1  high from the cycle after an accepted start until DONE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 error  out  1  sticky per command; valid while done=1 and held until the next start.
REQ-016 err_addr  out  5  word index of the first mismatch.
REQ-017 result  out  32  mismatch count (op 10) or checksum (op 11).

Function
REQ-018 States SHALL be: IDLE, WRITE, RD_ADDR, RD_WAIT, DONE.
REQ-019 Command operands SHALL be latched on start in IDLE; in other states start SHALL be ignored.
REQ-020 Word i SHALL be at index (base_word + i) mod 32, i.e. wrap from 31 to 0.
REQ-021 mem_addr SHALL be {24'b0, 1'b0, idx[4:0], 2'b00}, so bit 7 is always 0 and the IO region is never accessed.
REQ-022 op 00/01 SHALL use IDLE->WRITE; one word per cycle; mem_we=1 for exactly count cycles.
REQ-023 mem_datain SHALL be seed for op 00, and seed+i (mod 2^32) for op 01.
REQ-024 op 10/11 SHALL loop IDLE->RD_ADDR->RD_WAIT per word: address presented in RD_ADDR; mem_dataout sampled at the end of RD_WAIT; 2 cycles per word.
REQ-025 op 10 SHALL compare each word against seed+i; each mismatch increments result; the first mismatch sets error and err_addr.
REQ-026 op 11 SHALL set result = 32-bit wrapping sum of all words read, with error=0.
REQ-027 After the last word the FSM SHALL go to DONE, where done=1 for one cycle, then to IDLE.
REQ-028 count=0 SHALL go IDLE->DONE with no bus activity, result=0, error=0.
REQ-029 mem_we SHALL be 0 in every state other than WRITE.
REQ-030 mem_addr and mem_datain SHALL hold their last values when idle.

Reset
REQ-031 Asserting resetn low SHALL, asynchronously and at any time including mid-command, force IDLE.
REQ-032 On reset, mem_we, busy, done and error SHALL be 0, and mem_addr, mem_datain, err_addr and result SHALL be 0.
REQ-033 After reset the aborted command SHALL NOT resume and SHALL NOT produce a done pulse.

Configuration
REQ-034 With DMEM_MASTER_CHECKSUM_EN defined, op 11 SHALL behave per REQ-026.
REQ-035 Without DMEM_MASTER_CHECKSUM_EN, op 11 SHALL go IDLE->DONE with no bus activity, error=1, result=0, and no checksum adder shall be synthesized.

Verification
REQ-036 Fill-increment: op=01, base=4, count=3, seed=0x10 -> writes 0x10@0x10, 0x11@0x14, 0x12@0x18 on consecutive cycles; done 1 cycle later.
REQ-037 Wrap: op=00, base=30, count=4, seed=0xA5 -> addresses 0x78, 0x7C, 0x00, 0x04; bit 7 never set.
REQ-038 Check with a corrupted word: fill as in REQ-036, then overwrite word 5 with 0; check op=10 -> error=1, err_addr=5, result=1, busy for 6 cycles.
REQ-039 Checksum: words 0..3 = 1, 2, 3, 4; op=11, base=0, count=4 -> result=10; without the macro -> error=1, no mem_addr change.
REQ-040 Reset mid-WRITE at word 2 of 8 -> mem_we=0 immediately; no done pulse; next start executes normally.
REQ-041 count=0 and start during busy -> done after 1 cycle with no writes; a second start while busy is ignored.
